pwm_sum_sched: RTL and testbench

Frame scheduler in front of the registered four-contribution signed adder (`add4wsign`) in the ANS-PWM datapath. On every sample tick it opens a collection window and accepts one contribution from each of four producers via valid/ready. It then presents the frame to the adder, waits out the adder's register stage and publishes the registered sum to the PWM stage with a one-cycle strobe. Producers that miss the window contribute zero and are flagged.

---
 rtl/pwm_sum_pkg.sv | 22 ++
 rtl/sum_slot.sv | 46 ++++
 rtl/pwm_sum_sched.sv | 146 ++++++++++++++
 tb/tb_pwm_sum_sched.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_sum_pkg.sv
// Shared types and defaults for the PWM sum frame scheduler.
// Provides the scheduler state encoding, default widths and the contribution record.
// No logic lives here.
package pwm_sum_pkg;

  localparam int WIDTH_DEFAULT   = 16;
  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_ISSUE   = 2'd2,
    S_WAIT    = 2'd3
  } sched_state_e;

  // One producer contribution: unsigned magnitude plus subtract flag.
  typedef struct packed {
    logic [WIDTH_DEFAULT-1:0] val;
    logic                     sgn;
  } contrib_t;

endpackage

// File: rtl/sum_slot.sv
// Per-producer capture slot: holds one contribution per frame and generates ready.
// Latency: capture lands the cycle after valid&&ready; ready is combinational from open/got.
// Backpressure: ready drops once the slot has captured, so a repeat valid is never acknowledged.
//
// Ports: clk/rst, clear (start of frame), open (collection window), valid/val/sgn from the
// producer, ready/accept back to producer and FSM, got flag, cap_val/cap_sgn capture registers.
import pwm_sum_pkg::*;

module sum_slot #(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             open,
  input  logic             valid,
  input  logic [WIDTH-1:0] val,
  input  logic             sgn,
  output logic             ready,
  output logic             accept,
  output logic             got,
  output logic [WIDTH-1:0] cap_val,
  output logic             cap_sgn
);

  assign ready  = open && !got;
  assign accept = valid && ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      got     <= 1'b0;
      cap_val <= '0;
      cap_sgn <= 1'b0;
    end else if (clear) begin
      // An uncaptured slot must read as +0 so it adds nothing.
      got     <= 1'b0;
      cap_val <= '0;
      cap_sgn <= 1'b0;
    end else if (accept) begin
      got     <= 1'b1;
      cap_val <= val;
      cap_sgn <= sgn;
    end
  end

endmodule

// File: rtl/pwm_sum_sched.sv
// Frame scheduler feeding the registered four-input signed adder of the PWM datapath.
// Latency: tick to out_valid is 4 cycles minimum, TIMEOUT+3 cycles when a producer misses.
// Backpressure: each producer is acked once per frame; ticks while busy are dropped and flagged.
//
// Ports: clk/rst; tick sample strobe; c0..c3 valid/ready/val (+sgn for c1..c3) producers;
// add_c0..add_c3 and add_c1_sgn..add_c3_sgn adder operands, add_val registered adder result;
// out_val/out_valid published sum; busy, missed[3:0] per-channel misses, overrun pulse.
import pwm_sum_pkg::*;

module pwm_sum_sched #(
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [WIDTH-1:0] c0_val,
  input  logic             c0_valid,
  output logic             c0_ready,
  input  logic [WIDTH-1:0] c1_val,
  input  logic             c1_sgn,
  input  logic             c1_valid,
  output logic             c1_ready,
  input  logic [WIDTH-1:0] c2_val,
  input  logic             c2_sgn,
  input  logic             c2_valid,
  output logic             c2_ready,
  input  logic [WIDTH-1:0] c3_val,
  input  logic             c3_sgn,
  input  logic             c3_valid,
  output logic             c3_ready,
  output logic [WIDTH-1:0] add_c0,
  output logic [WIDTH-1:0] add_c1,
  output logic [WIDTH-1:0] add_c2,
  output logic [WIDTH-1:0] add_c3,
  output logic             add_c1_sgn,
  output logic             add_c2_sgn,
  output logic             add_c3_sgn,
  input  logic [WIDTH-1:0] add_val,
  output logic [WIDTH-1:0] out_val,
  output logic             out_valid,
  output logic             busy,
  output logic [3:0]       missed,
  output logic             overrun
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  sched_state_e state_q, state_d;
  logic [15:0]  cnt_q;
  logic [3:0]   got, acc;
  logic [3:0]   next_missed_q;
  logic         clear, open, collect_done;
  logic         unused_c0_sgn;

  assign open = (state_q == S_COLLECT);
  assign busy = (state_q != S_IDLE);

  // Capture registers drive the adder operands directly for the whole frame.
  sum_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk(clk), .rst(rst), .clear(clear), .open(open),
    .valid(c0_valid), .val(c0_val), .sgn(1'b0),
    .ready(c0_ready), .accept(acc[0]), .got(got[0]),
    .cap_val(add_c0), .cap_sgn(unused_c0_sgn)
  );

  sum_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk(clk), .rst(rst), .clear(clear), .open(open),
    .valid(c1_valid), .val(c1_val), .sgn(c1_sgn),
    .ready(c1_ready), .accept(acc[1]), .got(got[1]),
    .cap_val(add_c1), .cap_sgn(add_c1_sgn)
  );

  sum_slot #(.WIDTH(WIDTH)) u_slot2 (
    .clk(clk), .rst(rst), .clear(clear), .open(open),
    .valid(c2_valid), .val(c2_val), .sgn(c2_sgn),
    .ready(c2_ready), .accept(acc[2]), .got(got[2]),
    .cap_val(add_c2), .cap_sgn(add_c2_sgn)
  );

  sum_slot #(.WIDTH(WIDTH)) u_slot3 (
    .clk(clk), .rst(rst), .clear(clear), .open(open),
    .valid(c3_valid), .val(c3_val), .sgn(c3_sgn),
    .ready(c3_ready), .accept(acc[3]), .got(got[3]),
    .cap_val(add_c3), .cap_sgn(add_c3_sgn)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    clear        = 1'b0;
    collect_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick) begin
          clear   = 1'b1;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        // Completion is checked including this cycle's accepts, so a full set
        // arriving on the last timeout cycle still reports no misses.
        if (((got | acc) == 4'hF) || (cnt_q == TO_LAST)) begin
          collect_done = 1'b1;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      next_missed_q <= '0;
      out_val       <= '0;
      out_valid     <= 1'b0;
      missed        <= '0;
      overrun       <= 1'b0;
    end else begin
      if (clear)
        cnt_q <= '0;
      else if (open)
        cnt_q <= cnt_q + 16'd1;

      if (collect_done)
        next_missed_q <= ~(got | acc);

      // add_val is valid during WAIT: the adder registered the operands at the end of ISSUE.
      out_valid <= (state_q == S_WAIT);
      if (state_q == S_WAIT) begin
        out_val <= add_val;
        missed  <= next_missed_q;
      end

      overrun <= tick && (state_q != S_IDLE);
    end
  end

endmodule

// File: tb/tb_pwm_sum_sched.sv
module tb_pwm_sum_sched;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         tick;
  logic [W-1:0] c0_val, c1_val, c2_val, c3_val;
  logic         c1_sgn, c2_sgn, c3_sgn;
  logic         c0_valid, c1_valid, c2_valid, c3_valid;
  logic         c0_ready, c1_ready, c2_ready, c3_ready;
  logic [W-1:0] add_c0, add_c1, add_c2, add_c3;
  logic         add_c1_sgn, add_c2_sgn, add_c3_sgn;
  logic [W-1:0] add_val;
  logic [W-1:0] out_val;
  logic         out_valid, busy, overrun;
  logic [3:0]   missed;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  pwm_sum_sched #(.WIDTH(W), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .c0_val(c0_val), .c0_valid(c0_valid), .c0_ready(c0_ready),
    .c1_val(c1_val), .c1_sgn(c1_sgn), .c1_valid(c1_valid), .c1_ready(c1_ready),
    .c2_val(c2_val), .c2_sgn(c2_sgn), .c2_valid(c2_valid), .c2_ready(c2_ready),
    .c3_val(c3_val), .c3_sgn(c3_sgn), .c3_valid(c3_valid), .c3_ready(c3_ready),
    .add_c0(add_c0), .add_c1(add_c1), .add_c2(add_c2), .add_c3(add_c3),
    .add_c1_sgn(add_c1_sgn), .add_c2_sgn(add_c2_sgn), .add_c3_sgn(add_c3_sgn),
    .add_val(add_val),
    .out_val(out_val), .out_valid(out_valid), .busy(busy),
    .missed(missed), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the external registered signed adder.
  always @(posedge clk)
    add_val <= add_c0 + (add_c1_sgn ? -add_c1 : add_c1)
                      + (add_c2_sgn ? -add_c2 : add_c2)
                      + (add_c3_sgn ? -add_c3 : add_c3);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic [3:0] v, input logic [W-1:0] a0, a1, a2, a3,
                       input logic [3:1] s);
    c0_valid = v[0]; c1_valid = v[1]; c2_valid = v[2]; c3_valid = v[3];
    c0_val = a0; c1_val = a1; c2_val = a2; c3_val = a3;
    c1_sgn = s[1]; c2_sgn = s[2]; c3_sgn = s[3];
  endtask

  task automatic idle_inputs();
    drive(4'b0000, '0, '0, '0, '0, 3'b000);
  endtask

  // Called just after a clock edge: the current cycle becomes T, returns in T+1.
  task automatic start_frame();
    tick = 1'b1;
    cyc  = 0;
    step();
    tick = 1'b0;
  endtask

  task automatic wait_pub(input int limit);
    while (out_valid !== 1'b1 && cyc < limit) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick = 1'b0;
    idle_inputs();
    #1;
    n_checks++;
    if ({out_val, out_valid, busy, missed, overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got val=%h vld=%b busy=%b missed=%b ovr=%b, want all 0",
               out_val, out_valid, busy, missed, overrun);
    end
    n_checks++;
    if ({c0_ready, c1_ready, c2_ready, c3_ready, add_c0, add_c1, add_c2, add_c3,
         add_c1_sgn, add_c2_sgn, add_c3_sgn} !== '0) begin
      n_fail++;
      $display("FAIL reset_ready_add: got ready=%b%b%b%b add0=%h add1=%h, want 0",
               c0_ready, c1_ready, c2_ready, c3_ready, add_c0, add_c1);
    end
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_full_frame();
    start_frame();
    drive(4'b1111, 16'd1000, 16'd200, 16'd50, 16'd10, 3'b110);
    n_checks++;
    if ({busy, c0_ready, c1_ready, c2_ready, c3_ready} !== 5'b11111) begin
      n_fail++;
      $display("FAIL full_collect: got busy/ready=%b%b%b%b%b, want 11111",
               busy, c0_ready, c1_ready, c2_ready, c3_ready);
    end
    step();
    idle_inputs();
    n_checks++;
    if ({add_c0, add_c1, add_c2, add_c3, add_c1_sgn, add_c2_sgn, add_c3_sgn} !==
        {16'd1000, 16'd200, 16'd50, 16'd10, 3'b011}) begin
      n_fail++;
      $display("FAIL full_operands: got %0d %0d %0d %0d sgn=%b%b%b, want 1000 200 50 10 sgn=011",
               add_c0, add_c1, add_c2, add_c3, add_c1_sgn, add_c2_sgn, add_c3_sgn);
    end
    n_checks++;
    if ({c0_ready, c1_ready, c2_ready, c3_ready} !== 4'b0000) begin
      n_fail++;
      $display("FAIL full_issue_ready: got %b%b%b%b, want 0000",
               c0_ready, c1_ready, c2_ready, c3_ready);
    end
    wait_pub(20);
    n_checks++;
    if (cyc !== 4 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL full_latency: got T+%0d (out_valid=%b), want T+4", cyc, out_valid);
    end
    n_checks++;
    if (out_val !== 16'd1140 || missed !== 4'b0000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_result: got val=%0d missed=%b busy=%b, want 1140 0000 0",
               out_val, missed, busy);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0 || out_val !== 16'd1140) begin
      n_fail++;
      $display("FAIL full_hold: got vld=%b val=%0d, want 0 1140", out_valid, out_val);
    end
  endtask

  task automatic test_staggered();
    start_frame();
    drive(4'b1011, 16'd7, 16'd9, 16'd0, 16'd2, 3'b000);
    step();
    idle_inputs();
    n_checks++;
    if ({c0_ready, c1_ready, c2_ready, c3_ready} !== 4'b0010) begin
      n_fail++;
      $display("FAIL stag_ready_partial: got c0..c3=%b%b%b%b, want 0010",
               c0_ready, c1_ready, c2_ready, c3_ready);
    end
    step();
    step();
    step();
    drive(4'b0100, '0, '0, 16'd4, '0, 3'b010);
    n_checks++;
    if (c2_ready !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL stag_c2_open: got c2_ready=%b busy=%b at T+%0d, want 1 1", c2_ready, busy, cyc);
    end
    step();
    // A second c2 offer with a different value must be ignored.
    drive(4'b0100, '0, '0, 16'd100, '0, 3'b000);
    n_checks++;
    if (c2_ready !== 1'b0 || add_c2 !== 16'd4 || add_c2_sgn !== 1'b1) begin
      n_fail++;
      $display("FAIL stag_c2_once: got ready=%b add_c2=%0d sgn=%b, want 0 4 1",
               c2_ready, add_c2, add_c2_sgn);
    end
    step();
    idle_inputs();
    wait_pub(20);
    n_checks++;
    if (cyc !== 8 || out_val !== 16'd14 || missed !== 4'b0000) begin
      n_fail++;
      $display("FAIL stag_result: got T+%0d val=%0d missed=%b, want T+8 14 0000",
               cyc, out_val, missed);
    end
    step();
  endtask

  task automatic test_timeout();
    start_frame();
    drive(4'b0111, 16'd5, 16'd3, 16'd1, 16'd0, 3'b010);
    step();
    // c1 keeps offering a different value after its capture.
    drive(4'b0010, '0, 16'd99, '0, '0, 3'b001);
    n_checks++;
    if (c1_ready !== 1'b0 || c3_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL to_ready: got c1_ready=%b c3_ready=%b, want 0 1", c1_ready, c3_ready);
    end
    while (cyc < 8) step();
    n_checks++;
    if (busy !== 1'b1 || c3_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL to_last_collect: got busy=%b c3_ready=%b at T+8, want 1 1", busy, c3_ready);
    end
    step();
    idle_inputs();
    n_checks++;
    if (c3_ready !== 1'b0 || add_c1 !== 16'd3 || add_c1_sgn !== 1'b0) begin
      n_fail++;
      $display("FAIL to_issue: got c3_ready=%b add_c1=%0d sgn=%b, want 0 3 0",
               c3_ready, add_c1, add_c1_sgn);
    end
    wait_pub(30);
    n_checks++;
    if (cyc !== 11 || out_val !== 16'd7 || missed !== 4'b1000) begin
      n_fail++;
      $display("FAIL to_result: got T+%0d val=%0d missed=%b, want T+11 7 1000",
               cyc, out_val, missed);
    end
    step();
  endtask

  task automatic test_wrap();
    start_frame();
    drive(4'b1111, 16'd0, 16'd1, 16'd0, 16'd0, 3'b001);
    step();
    idle_inputs();
    wait_pub(20);
    n_checks++;
    if (cyc !== 4 || out_val !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL wrap_under: got T+%0d val=%h, want T+4 ffff", cyc, out_val);
    end
    step();
    start_frame();
    drive(4'b1111, 16'hFFFF, 16'd2, 16'd0, 16'd0, 3'b000);
    step();
    idle_inputs();
    wait_pub(20);
    n_checks++;
    if (cyc !== 4 || out_val !== 16'h0001) begin
      n_fail++;
      $display("FAIL wrap_over: got T+%0d val=%h, want T+4 0001", cyc, out_val);
    end
    step();
  endtask

  task automatic test_overrun();
    start_frame();
    drive(4'b1111, 16'd20, 16'd3, 16'd0, 16'd0, 3'b000);
    step();
    idle_inputs();
    tick = 1'b1;
    step();
    tick = 1'b0;
    n_checks++;
    if (overrun !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_pulse: got overrun=%b out_valid=%b at T+3, want 1 0", overrun, out_valid);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b1 || overrun !== 1'b0 || out_val !== 16'd23) begin
      n_fail++;
      $display("FAIL ovr_publish: got vld=%b ovr=%b val=%0d at T+4, want 1 0 23",
               out_valid, overrun, out_val);
    end
    // Tick on the publish cycle opens a fresh frame.
    tick = 1'b1;
    cyc  = 0;
    step();
    tick = 1'b0;
    n_checks++;
    if (overrun !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0 || c0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_back_to_back: got ovr=%b busy=%b vld=%b c0_ready=%b, want 0 1 0 1",
               overrun, busy, out_valid, c0_ready);
    end
    drive(4'b1111, 16'd8, 16'd1, 16'd1, 16'd1, 3'b100);
    step();
    idle_inputs();
    wait_pub(20);
    n_checks++;
    if (cyc !== 4 || out_val !== 16'd9) begin
      n_fail++;
      $display("FAIL ovr_second_frame: got T+%0d val=%0d, want T+4 9", cyc, out_val);
    end
    step();
  endtask

  task automatic test_reset_mid_frame();
    start_frame();
    drive(4'b1111, 16'd300, 16'd30, 16'd3, 16'd0, 3'b000);
    step();
    idle_inputs();
    step();
    n_checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_in_wait: got busy=%b vld=%b at T+3, want 1 0", busy, out_valid);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({out_val, out_valid, busy, missed, overrun, add_c0, add_c1, add_c2} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_clear: got val=%h vld=%b busy=%b add0=%h, want all 0",
               out_val, out_valid, busy, add_c0);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_no_publish: got vld=%b busy=%b %0d cycles after reset, want 0 0",
                 out_valid, busy, i + 1);
      end
    end
    start_frame();
    drive(4'b1111, 16'd1, 16'd2, 16'd3, 16'd4, 3'b000);
    step();
    idle_inputs();
    wait_pub(20);
    n_checks++;
    if (cyc !== 4 || out_val !== 16'd10 || missed !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstmid_clean_frame: got T+%0d val=%0d missed=%b, want T+4 10 0000",
               cyc, out_val, missed);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_staggered();
    test_timeout();
    test_wrap();
    test_overrun();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
